pulse_stretcher: RTL and testbench

- Converts single-cycle strobes into clean level windows of fixed length, with a minimum low gap between windows. It is the inverse of the team's edge-to-pulse detector.
- Drives LEDs, enables and handshake levels from one-cycle events generated elsewhere.
- In non-retrigger mode, pulses arriving while busy are queued, so every accepted pulse produces exactly one window.

---
 rtl/pulse_stretcher_if.sv | 30 +++
 rtl/pulse_stretcher.sv | 149 ++++++++++++++
 tb/tb_pulse_stretcher.sv | 310 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pulse_stretcher_if.sv
// Bundle of the strobe input and the stretched-level status outputs.
// The design drives the status signals and the bench drives the strobe.
interface pulse_stretcher_if #(
    parameter int PEND_W = 3
);
    logic              pulse_in;
    logic              level_out;
    logic              busy;
    logic              done;
    logic [PEND_W-1:0] pending;
    logic              overflow;

    modport slave (
        input  pulse_in,
        output level_out,
        output busy,
        output done,
        output pending,
        output overflow
    );

    modport master (
        output pulse_in,
        input  level_out,
        input  busy,
        input  done,
        input  pending,
        input  overflow
    );
endinterface

// File: rtl/pulse_stretcher.sv
// Stretches single-cycle strobes into fixed-length high windows separated by
// a minimum low gap. Strobes that arrive while a window or gap is running are
// counted in a saturating pending counter (or restart the window when
// RETRIGGER is set), so every accepted strobe yields exactly one window.
module pulse_stretcher #(
    parameter int HIGH_CYCLES = 4,
    parameter int GAP_CYCLES  = 2,
    parameter int PEND_W      = 3,
    parameter int RETRIGGER   = 0
) (
    input  logic clk,
    input  logic rst,
    pulse_stretcher_if.slave bus
);
    // The counter only ever holds values up to max(HIGH, GAP) - 1.
    localparam int CNT_MAX = (HIGH_CYCLES > GAP_CYCLES) ? HIGH_CYCLES : GAP_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0]  HIGH_LOAD = CNT_W'(HIGH_CYCLES - 1);
    localparam logic [CNT_W-1:0]  GAP_LOAD  = (GAP_CYCLES > 0) ? CNT_W'(GAP_CYCLES - 1) : '0;
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [PEND_W-1:0] PEND_MAX  = '1;
    localparam logic [PEND_W-1:0] PEND_ONE  = PEND_W'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t            state_reg, state_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic [PEND_W-1:0] pend_reg, pend_next;
    logic              ovf_reg, ovf_next;
    logic              done_reg, done_next;
    logic              level_reg, level_next;

    logic              inc;
    logic              dec;
    logic              start_eval;

    // State register; level and done are registered alongside the state so
    // all outputs change on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            pend_reg  <= '0;
            ovf_reg   <= 1'b0;
            done_reg  <= 1'b0;
            level_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            pend_reg  <= pend_next;
            ovf_reg   <= ovf_next;
            done_reg  <= done_next;
            level_reg <= level_next;
        end
    end

    // Next-state logic: window/gap sequencing, start rule and pending bookkeeping.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        pend_next  = pend_reg;
        ovf_next   = ovf_reg;
        done_next  = 1'b0;
        inc        = 1'b0;
        dec        = 1'b0;
        start_eval = 1'b0;

        case (state_reg)
            IDLE: begin
                if (bus.pulse_in) begin
                    state_next = HIGH;
                    cnt_next   = HIGH_LOAD;
                end
            end
            HIGH: begin
                if ((RETRIGGER != 0) && bus.pulse_in) begin
                    // Restart the window; this also swallows the done of the
                    // window that would otherwise have ended now.
                    cnt_next = HIGH_LOAD;
                end else if (cnt_reg == '0) begin
                    done_next = 1'b1;
                    if (GAP_CYCLES > 0) begin
                        state_next = GAP;
                        cnt_next   = GAP_LOAD;
                        inc        = bus.pulse_in;
                    end else begin
                        start_eval = 1'b1;
                    end
                end else begin
                    cnt_next = cnt_reg - CNT_ONE;
                    inc      = bus.pulse_in;
                end
            end
            GAP: begin
                if (cnt_reg == '0) begin
                    start_eval = 1'b1;
                end else begin
                    cnt_next = cnt_reg - CNT_ONE;
                    inc      = bus.pulse_in;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase

        // Start rule: a queued event takes priority, and a same-cycle strobe
        // then simply replaces it in the queue.
        if (start_eval) begin
            if (pend_reg != '0) begin
                state_next = HIGH;
                cnt_next   = HIGH_LOAD;
                dec        = 1'b1;
                inc        = bus.pulse_in;
            end else if (bus.pulse_in) begin
                state_next = HIGH;
                cnt_next   = HIGH_LOAD;
            end else begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        end

        // Pending counter saturates; a dropped event latches overflow.
        if (inc && !dec) begin
            if (pend_reg == PEND_MAX) begin
                ovf_next = 1'b1;
            end else begin
                pend_next = pend_reg + PEND_ONE;
            end
        end else if (dec && !inc) begin
            pend_next = pend_reg - PEND_ONE;
        end

        level_next = (state_next == HIGH);
    end

    assign bus.level_out = level_reg;
    assign bus.busy      = (state_reg != IDLE);
    assign bus.done      = done_reg;
    assign bus.pending   = pend_reg;
    assign bus.overflow  = ovf_reg;
endmodule

// File: tb/tb_pulse_stretcher.sv
// Bench for pulse_stretcher: three configurations (defaults, retrigger,
// zero gap) checked cycle by cycle against a scoreboard fed by a reference
// model, plus fixed expectations taken from the scenario descriptions.
module tb_pulse_stretcher;
    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    pulse_stretcher_if #(.PEND_W(3)) if_def ();
    pulse_stretcher_if #(.PEND_W(3)) if_rt  ();
    pulse_stretcher_if #(.PEND_W(3)) if_g0  ();

    pulse_stretcher #(.HIGH_CYCLES(4), .GAP_CYCLES(2), .PEND_W(3), .RETRIGGER(0))
        u_def (.clk(clk), .rst(rst), .bus(if_def));
    pulse_stretcher #(.HIGH_CYCLES(4), .GAP_CYCLES(2), .PEND_W(3), .RETRIGGER(1))
        u_rt  (.clk(clk), .rst(rst), .bus(if_rt));
    pulse_stretcher #(.HIGH_CYCLES(4), .GAP_CYCLES(0), .PEND_W(3), .RETRIGGER(0))
        u_g0  (.clk(clk), .rst(rst), .bus(if_g0));

    int total = 0;
    int bad   = 0;

    // Expected output vector: {level, busy, done, pending[2:0], overflow}
    logic [6:0] exp_q[$];

    // Reference model state (for whichever configuration a test targets)
    int m_state;  // 0 idle, 1 high, 2 gap
    int m_cnt;
    int m_pend;
    bit m_ovf;
    bit m_done;

    function automatic logic [6:0] obs(input int cfg);
        case (cfg)
            1:       return {if_rt.level_out, if_rt.busy, if_rt.done, if_rt.pending, if_rt.overflow};
            2:       return {if_g0.level_out, if_g0.busy, if_g0.done, if_g0.pending, if_g0.overflow};
            default: return {if_def.level_out, if_def.busy, if_def.done, if_def.pending, if_def.overflow};
        endcase
    endfunction

    // Behavioural model of one clock edge, written from the window rules.
    task automatic model_step(input int cfg, input bit p, input bit r);
        int  gap_len;
        bit  rt;
        bit  queue_it;
        bit  at_start;
        gap_len  = (cfg == 2) ? 0 : 2;
        rt       = (cfg == 1);
        queue_it = 1'b0;
        at_start = 1'b0;
        m_done   = 1'b0;
        if (r) begin
            m_state = 0; m_cnt = 0; m_pend = 0; m_ovf = 1'b0;
            return;
        end
        if (m_state == 0) begin
            if (p) begin m_state = 1; m_cnt = 3; end
        end else if (m_state == 1) begin
            if (rt && p) begin
                m_cnt = 3;
            end else if (m_cnt == 0) begin
                m_done = 1'b1;
                if (gap_len > 0) begin
                    m_state = 2; m_cnt = gap_len - 1; queue_it = p;
                end else begin
                    at_start = 1'b1;
                end
            end else begin
                m_cnt = m_cnt - 1; queue_it = p;
            end
        end else begin
            if (m_cnt == 0) at_start = 1'b1;
            else begin m_cnt = m_cnt - 1; queue_it = p; end
        end
        if (at_start) begin
            if (m_pend > 0) begin
                m_state = 1; m_cnt = 3;
                if (!p) m_pend = m_pend - 1;
            end else if (p) begin
                m_state = 1; m_cnt = 3;
            end else begin
                m_state = 0; m_cnt = 0;
            end
        end
        if (queue_it) begin
            if (m_pend == 7) m_ovf = 1'b1;
            else m_pend = m_pend + 1;
        end
    endtask

    // Drive one cycle of stimulus to the target, push the model's expectation,
    // then step past the edge so outputs can be sampled.
    task automatic advance(input int cfg, input bit p, input bit r);
        logic [6:0] e;
        rst             = r;
        if_def.pulse_in = (cfg == 0) ? p : 1'b0;
        if_rt.pulse_in  = (cfg == 1) ? p : 1'b0;
        if_g0.pulse_in  = (cfg == 2) ? p : 1'b0;
        model_step(cfg, p, r);
        e = {m_state == 1, m_state != 0, m_done, 3'(m_pend), m_ovf};
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [6:0] e, o;
        for (int c = 0; c < 3; c++) begin
            advance(0, 1'b0, c < 2);
            e = exp_q.pop_front();
            o = obs(0);
            total++;
            if (o !== e) begin
                bad++;
                $display("FAIL reset_sb cyc=%0d got=%b want=%b", c + 1, o, e);
            end
            total++;
            if (o !== 7'b0) begin
                bad++;
                $display("FAIL reset_zero cyc=%0d got=%b want=%b", c + 1, o, 7'b0);
            end
        end
        $display("test_reset done");
    endtask

    task automatic test_single();
        logic [6:0] e, o;
        int cyc;
        for (int c = 0; c < 22; c++) begin
            advance(0, c == 10, c < 2);
            cyc = c + 1;
            e = exp_q.pop_front();
            o = obs(0);
            total++;
            if (o !== e) begin
                bad++;
                $display("FAIL single_sb cyc=%0d got=%b want=%b", cyc, o, e);
            end
            if (cyc >= 3) begin
                total++;
                if ({o[6], o[5], o[4], o[3:1]} !== {cyc >= 11 && cyc <= 14, cyc >= 11 && cyc <= 16, cyc == 15, 3'd0}) begin
                    bad++;
                    $display("FAIL single_fixed cyc=%0d got=%b (level/busy/done/pend)", cyc, o[6:1]);
                end
            end
        end
        $display("test_single done");
    endtask

    task automatic test_queue_two();
        logic [6:0] e, o;
        int cyc;
        for (int c = 0; c < 26; c++) begin
            advance(0, c == 10 || c == 12, c < 2);
            cyc = c + 1;
            e = exp_q.pop_front();
            o = obs(0);
            total++;
            if (o !== e) begin
                bad++;
                $display("FAIL queue_sb cyc=%0d got=%b want=%b", cyc, o, e);
            end
            if (cyc >= 3) begin
                total++;
                if ({o[6], o[4], o[3:1]} !== {(cyc >= 11 && cyc <= 14) || (cyc >= 17 && cyc <= 20),
                                              cyc == 15 || cyc == 21,
                                              (cyc >= 13 && cyc <= 16) ? 3'd1 : 3'd0}) begin
                    bad++;
                    $display("FAIL queue_fixed cyc=%0d got=%b (level/done/pend)", cyc, {o[6], o[4], o[3:1]});
                end
            end
        end
        $display("test_queue_two done");
    endtask

    task automatic test_saturate();
        logic [6:0] e, o;
        int max_pend;
        bit ovf_seen;
        max_pend = 0;
        ovf_seen = 1'b0;
        for (int c = 0; c < 160; c++) begin
            advance(0, c >= 10 && c <= 30, c < 2);
            e = exp_q.pop_front();
            o = obs(0);
            total++;
            if (o !== e) begin
                bad++;
                $display("FAIL sat_sb cyc=%0d got=%b want=%b", c + 1, o, e);
            end
            if (int'(o[3:1]) > max_pend) max_pend = int'(o[3:1]);
            if (ovf_seen && !o[0]) begin
                total++;
                bad++;
                $display("FAIL sat_sticky cyc=%0d got=0 want=1", c + 1);
            end
            if (o[0]) ovf_seen = 1'b1;
        end
        o = obs(0);
        total++;
        if (max_pend != 7) begin
            bad++;
            $display("FAIL sat_max got=%0d want=7", max_pend);
        end
        total++;
        if ({o[5], o[3:1], o[0]} !== {1'b0, 3'd0, 1'b1}) begin
            bad++;
            $display("FAIL sat_final got busy/pend/ovf=%b want=%b", {o[5], o[3:1], o[0]}, 5'b00001);
        end
        $display("test_saturate done");
    endtask

    task automatic test_retrigger();
        logic [6:0] e, o;
        int cyc;
        for (int c = 0; c < 22; c++) begin
            advance(1, c == 10 || c == 12, c < 2);
            cyc = c + 1;
            e = exp_q.pop_front();
            o = obs(1);
            total++;
            if (o !== e) begin
                bad++;
                $display("FAIL retrig_sb cyc=%0d got=%b want=%b", cyc, o, e);
            end
            if (cyc >= 3) begin
                total++;
                if ({o[6], o[4], o[3:1]} !== {cyc >= 11 && cyc <= 16, cyc == 17, 3'd0}) begin
                    bad++;
                    $display("FAIL retrig_fixed cyc=%0d got=%b (level/done/pend)", cyc, {o[6], o[4], o[3:1]});
                end
            end
        end
        $display("test_retrigger done");
    endtask

    task automatic test_no_gap();
        logic [6:0] e, o;
        int cyc;
        for (int c = 0; c < 24; c++) begin
            advance(2, c == 10 || c == 11, c < 2);
            cyc = c + 1;
            e = exp_q.pop_front();
            o = obs(2);
            total++;
            if (o !== e) begin
                bad++;
                $display("FAIL nogap_sb cyc=%0d got=%b want=%b", cyc, o, e);
            end
            if (cyc >= 3) begin
                total++;
                if ({o[6], o[4]} !== {cyc >= 11 && cyc <= 18, cyc == 15 || cyc == 19}) begin
                    bad++;
                    $display("FAIL nogap_fixed cyc=%0d got=%b (level/done)", cyc, {o[6], o[4]});
                end
            end
        end
        $display("test_no_gap done");
    endtask

    task automatic test_mid_reset();
        logic [6:0] e, o;
        int cyc;
        for (int c = 0; c < 28; c++) begin
            advance(0, c == 10 || c == 11 || c == 12 || c == 20, c < 2 || c == 13);
            cyc = c + 1;
            e = exp_q.pop_front();
            o = obs(0);
            total++;
            if (o !== e) begin
                bad++;
                $display("FAIL midrst_sb cyc=%0d got=%b want=%b", cyc, o, e);
            end
            if (cyc >= 14 && cyc <= 20) begin
                total++;
                if (o !== 7'b0) begin
                    bad++;
                    $display("FAIL midrst_zero cyc=%0d got=%b want=%b", cyc, o, 7'b0);
                end
            end
            if (cyc >= 21) begin
                total++;
                if (o[6] !== (cyc <= 24)) begin
                    bad++;
                    $display("FAIL midrst_level cyc=%0d got=%b want=%b", cyc, o[6], cyc <= 24);
                end
            end
        end
        $display("test_mid_reset done");
    endtask

    initial begin
        if_def.pulse_in = 1'b0;
        if_rt.pulse_in  = 1'b0;
        if_g0.pulse_in  = 1'b0;
        m_state = 0; m_cnt = 0; m_pend = 0; m_ovf = 1'b0; m_done = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_single();
        test_queue_two();
        test_saturate();
        test_retrigger();
        test_no_gap();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
